// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: per-stage stall requests and exception redirect in,
// hold mask, flush/redirect and performance counters out.
interface pipe_ctrl_if #(
   parameter int NSTAGE = 6,
   parameter int PC_W   = 32,
   parameter int CNT_W  = 32
) ();
   logic [NSTAGE-1:0] stallreq;
   logic              except_req;
   logic [PC_W-1:0]   except_pc;
   logic              clr_cnt;
   logic [NSTAGE-1:0] stall;
   logic              flush;
   logic [PC_W-1:0]   new_pc;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic              stall_timeout;

   modport master (
      output stallreq, except_req, except_pc, clr_cnt,
      input  stall, flush, new_pc, stall_cnt, flush_cnt, stall_timeout
   );

   modport slave (
      input  stallreq, except_req, except_pc, clr_cnt,
      output stall, flush, new_pc, stall_cnt, flush_cnt, stall_timeout
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: thermometer stall mask, timed flush with PC
// redirect, and saturating stall/flush counters with a sticky stall timeout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | normal operation, stall mask follows stallreq
// S_FLUSH | flush asserted for FLUSH_CYC cycles, stall forced to zero
module pipe_ctrl #(
   parameter int NSTAGE    = 6,
   parameter int PC_W      = 32,
   parameter int CNT_W     = 32,
   parameter int FLUSH_CYC = 1,
   parameter int STALL_TMO = 1024
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
);
   localparam int CW = $clog2(STALL_TMO + 1);
   localparam logic [3:0]       FL_LOAD = 4'(FLUSH_CYC - 1);
   localparam logic [CW-1:0]    TMO_M1  = CW'(STALL_TMO - 1);
   localparam logic [CW-1:0]    TMO_MAX = CW'(STALL_TMO);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   state_t            state_q, state_d;
   logic [3:0]        fl_cnt_q, fl_cnt_d;
   logic [PC_W-1:0]   new_pc_q, new_pc_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [CW-1:0]     consec_q, consec_d;
   logic              tmo_q, tmo_d;
   logic [NSTAGE-1:0] mask;
   logic              seen;
   logic              stall_nz;
   logic              flush_start;

   // Highest requesting stage holds itself and everything upstream of it.
   always_comb begin
      mask = '0;
      seen = 1'b0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         seen    = seen | bus.stallreq[k];
         mask[k] = seen;
      end
      if (rst || state_q != S_IDLE) mask = '0;
   end

   assign stall_nz = |mask;

   always_comb begin
      state_d     = state_q;
      fl_cnt_d    = fl_cnt_q;
      new_pc_d    = new_pc_q;
      flush_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.except_req) begin
               state_d     = S_FLUSH;
               fl_cnt_d    = FL_LOAD;
               new_pc_d    = bus.except_pc;
               flush_start = 1'b1;
            end
         end
         S_FLUSH: begin
            if (fl_cnt_q == 4'd0) state_d = S_IDLE;
            else                  fl_cnt_d = fl_cnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      consec_d    = consec_q;
      tmo_d       = tmo_q;
      if (bus.clr_cnt) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
         consec_d    = '0;
         tmo_d       = 1'b0;
      end else begin
         if (stall_nz && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
         if (flush_start && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
         if (!stall_nz)              consec_d = '0;
         else if (consec_q < TMO_MAX) consec_d = consec_q + CW'(1);
         if (stall_nz && consec_q >= TMO_M1) tmo_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         fl_cnt_q    <= '0;
         new_pc_q    <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         consec_q    <= '0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fl_cnt_q    <= fl_cnt_d;
         new_pc_q    <= new_pc_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         consec_q    <= consec_d;
         tmo_q       <= tmo_d;
      end
   end

   assign bus.stall         = mask;
   assign bus.flush         = (state_q == S_FLUSH);
   assign bus.new_pc        = new_pc_q;
   assign bus.stall_cnt     = stall_cnt_q;
   assign bus.flush_cnt     = flush_cnt_q;
   assign bus.stall_timeout = tmo_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall masks, flush timing/redirect, counters,
// timeout, saturation, and reset behaviour. Configured with CNT_W=4.
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   pipe_ctrl_if #(.NSTAGE(6), .PC_W(32), .CNT_W(4)) bus ();

   pipe_ctrl #(
      .NSTAGE(6), .PC_W(32), .CNT_W(4), .FLUSH_CYC(2), .STALL_TMO(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      bus.stallreq   = '0;
      bus.except_req = 1'b0;
      bus.except_pc  = '0;
      bus.clr_cnt    = 1'b0;
      tick();
      tick();

      bus.stallreq = 6'b111111;
      settle();
      chk("rst_stall", bus.stall, 6'b000000);
      chk("rst_flush", bus.flush, 1'b0);
      chk("rst_newpc", bus.new_pc, 32'h0);
      chk("rst_scnt", bus.stall_cnt, 4'd0);
      chk("rst_fcnt", bus.flush_cnt, 4'd0);
      chk("rst_tmo", bus.stall_timeout, 1'b0);

      bus.stallreq = '0;
      rst = 1'b0;
      tick();

      bus.stallreq = 6'b000100; settle(); chk("mask_id", bus.stall, 6'b000111);
      bus.stallreq = 6'b001100; settle(); chk("mask_ex", bus.stall, 6'b001111);
      bus.stallreq = 6'b000000; settle(); chk("mask_none", bus.stall, 6'b000000);
      bus.stallreq = 6'b100001; settle(); chk("mask_top", bus.stall, 6'b111111);
      bus.stallreq = 6'b000001; settle(); chk("mask_pc", bus.stall, 6'b000001);

      // exception coincident with a stall request
      bus.stallreq   = 6'b000100;
      bus.except_req = 1'b1;
      bus.except_pc  = 32'hBFC00380;
      settle();
      chk("exc_stall", bus.stall, 6'b000111);
      chk("exc_noflush", bus.flush, 1'b0);
      tick();
      bus.except_req = 1'b1;
      bus.except_pc  = 32'h12345678;
      settle();
      chk("fl1_flush", bus.flush, 1'b1);
      chk("fl1_stall", bus.stall, 6'b000000);
      chk("fl1_newpc", bus.new_pc, 32'hBFC00380);
      chk("fl1_fcnt", bus.flush_cnt, 4'd1);
      bus.stallreq = '0;
      tick();
      settle();
      chk("fl2_flush", bus.flush, 1'b1);
      chk("fl2_newpc", bus.new_pc, 32'hBFC00380);
      chk("fl2_stall", bus.stall, 6'b000000);
      tick();
      bus.except_req = 1'b0;
      settle();
      chk("post_flush", bus.flush, 1'b0);
      chk("post_fcnt", bus.flush_cnt, 4'd1);
      chk("post_newpc", bus.new_pc, 32'hBFC00380);
      chk("post_scnt", bus.stall_cnt, 4'd1);
      tick();
      chk("no_queue", bus.flush, 1'b0);

      bus.clr_cnt = 1'b1;
      tick();
      bus.clr_cnt = 1'b0;
      chk("clr_scnt", bus.stall_cnt, 4'd0);
      chk("clr_fcnt", bus.flush_cnt, 4'd0);

      // 7-cycle run then a gap: no timeout
      bus.stallreq = 6'b000010;
      for (int i = 0; i < 7; i++) tick();
      bus.stallreq = '0;
      tick();
      chk("run7_tmo", bus.stall_timeout, 1'b0);
      chk("run7_scnt", bus.stall_cnt, 4'd7);
      bus.stallreq = 6'b000010;
      tick();
      chk("run7_restart", bus.stall_timeout, 1'b0);

      bus.clr_cnt = 1'b1;
      bus.stallreq = '0;
      tick();
      bus.clr_cnt = 1'b0;

      bus.stallreq = 6'b010000;
      for (int i = 0; i < 7; i++) tick();
      chk("run8_pre", bus.stall_timeout, 1'b0);
      tick();
      chk("run8_tmo", bus.stall_timeout, 1'b1);
      chk("run8_scnt", bus.stall_cnt, 4'd8);
      bus.stallreq = '0;
      tick();
      chk("tmo_sticky", bus.stall_timeout, 1'b1);

      bus.clr_cnt = 1'b1;
      tick();
      bus.clr_cnt = 1'b0;
      chk("clr_tmo", bus.stall_timeout, 1'b0);

      bus.stallreq = 6'b000001;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_scnt", bus.stall_cnt, 4'd15);
      bus.clr_cnt = 1'b1;
      tick();
      bus.clr_cnt = 1'b0;
      chk("clr_over_inc", bus.stall_cnt, 4'd0);
      chk("clr_over_tmo", bus.stall_timeout, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      chk("consec_cleared", bus.stall_timeout, 1'b0);
      tick();
      chk("consec_8", bus.stall_timeout, 1'b1);
      bus.stallreq = '0;

      // reset during the first flush cycle
      bus.except_req = 1'b1;
      bus.except_pc  = 32'hDEAD0000;
      tick();
      bus.except_req = 1'b0;
      chk("rf_flush", bus.flush, 1'b1);
      chk("rf_fcnt", bus.flush_cnt, 4'd1);
      rst = 1'b1;
      tick();
      chk("rf_abort", bus.flush, 1'b0);
      chk("rf_newpc", bus.new_pc, 32'h0);
      chk("rf_fcnt0", bus.flush_cnt, 4'd0);
      chk("rf_scnt0", bus.stall_cnt, 4'd0);
      chk("rf_tmo0", bus.stall_timeout, 1'b0);
      rst = 1'b0;
      tick();
      chk("rf_noresume", bus.flush, 1'b0);

      // exception coincident with reset is dropped
      rst = 1'b1;
      bus.except_req = 1'b1;
      bus.except_pc  = 32'h00001234;
      tick();
      rst = 1'b0;
      bus.except_req = 1'b0;
      tick();
      chk("rx_flush", bus.flush, 1'b0);
      chk("rx_newpc", bus.new_pc, 32'h0);
      chk("rx_fcnt", bus.flush_cnt, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
